// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment codes are active-low: bit7 = dp, bits6:0 = g,f,e,d,c,b,a.
package digit_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex digit to segment pattern with the decimal point off.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/digit_scan_ctrl_hex7seg.sv
// Combinational hex nibble + decimal point to active-low segment lookup.
// The parent registers the result.
module hex7seg
  import digit_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_seg = SEG_TABLE[i_nibble];
    if (i_dp) o_seg[7] = 1'b0;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display with
// double-buffered display data committed at frame boundaries.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV    = 50000,
  parameter int BLANK  = 1000,
  parameter int DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp,
  input  logic        load,
  output logic [2:0]  sel,
  output logic        sel_en,
  output logic [7:0]  seg,
  output logic        frame_tick,
  output logic        pending
);

  localparam int             CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK - 1);
  localparam logic [2:0]     SEL_LAST   = 3'(DIGITS - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_sel, w_sel_nxt;
  logic [31:0]   r_active_data, w_active_data_nxt;
  logic [7:0]    r_active_dp, w_active_dp_nxt;
  logic [31:0]   r_staged_data, w_staged_data_nxt;
  logic [7:0]    r_staged_dp, w_staged_dp_nxt;
  logic          r_pending, w_pending_nxt;
  logic          r_sel_en;
  logic [7:0]    r_seg;
  logic          r_frame_tick;
  logic          w_slot_end;
  logic          w_boundary;
  logic [3:0]    w_nibble;
  logic          w_dp_bit;
  logic [7:0]    w_seg_show;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = ST_SHOW;
      ST_SHOW:  if (r_cnt == CNT_LAST)   w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_BLANK;
    endcase
  end

  assign w_slot_end = (r_state == ST_SHOW) && (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_sel == SEL_LAST);
  assign w_cnt_nxt  = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
  assign w_sel_nxt  = !w_slot_end ? r_sel : (w_boundary ? 3'd0 : r_sel + 3'd1);

  // A load on the boundary edge bypasses staging and goes straight to active.
  always_comb begin
    w_active_data_nxt = r_active_data;
    w_active_dp_nxt   = r_active_dp;
    w_staged_data_nxt = r_staged_data;
    w_staged_dp_nxt   = r_staged_dp;
    w_pending_nxt     = r_pending;
    if (load) begin
      w_staged_data_nxt = disp_data;
      w_staged_dp_nxt   = dp;
    end
    if (w_boundary) begin
      w_pending_nxt = 1'b0;
      if (load) begin
        w_active_data_nxt = disp_data;
        w_active_dp_nxt   = dp;
      end else if (r_pending) begin
        w_active_data_nxt = r_staged_data;
        w_active_dp_nxt   = r_staged_dp;
      end
    end else if (load) begin
      w_pending_nxt = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they describe the same cycle as the state.
  assign w_nibble = w_active_data_nxt[{w_sel_nxt, 2'b00} +: 4];
  assign w_dp_bit = w_active_dp_nxt[w_sel_nxt];

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .i_dp     (w_dp_bit),
    .o_seg    (w_seg_show)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_active_data <= '0;
      r_active_dp   <= '0;
      r_staged_data <= '0;
      r_staged_dp   <= '0;
      r_pending     <= 1'b0;
      r_sel_en      <= 1'b0;
      r_seg         <= SEG_OFF;
      r_frame_tick  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sel         <= w_sel_nxt;
      r_active_data <= w_active_data_nxt;
      r_active_dp   <= w_active_dp_nxt;
      r_staged_data <= w_staged_data_nxt;
      r_staged_dp   <= w_staged_dp_nxt;
      r_pending     <= w_pending_nxt;
      r_sel_en      <= (w_state_nxt == ST_SHOW);
      r_seg         <= (w_state_nxt == ST_SHOW) ? w_seg_show : SEG_OFF;
      r_frame_tick  <= w_boundary;
    end
  end

  assign sel        = r_sel;
  assign sel_en     = r_sel_en;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized self-checking bench for digit_scan_ctrl against a cycle-indexed
// reference model of slot timing and the double-buffered display data.
module tb_digit_scan_ctrl;

  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int DIGITS = 8;
  localparam int FRAME  = DIV * DIGITS;

  logic        clk;
  logic        rst_n;
  logic [31:0] disp_data;
  logic [7:0]  dp;
  logic        load;
  logic [2:0]  sel;
  logic        sel_en;
  logic [7:0]  seg;
  logic        frame_tick;
  logic        pending;

  digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_data  (disp_data),
    .dp         (dp),
    .load       (load),
    .sel        (sel),
    .sel_en     (sel_en),
    .seg        (seg),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ref_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int          n_checks = 0;
  int          n_errors = 0;
  int          t;
  logic [31:0] m_active, m_staged;
  logic [7:0]  m_adp, m_sdp;
  logic        m_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_active = '0; m_staged = '0;
    m_adp = '0; m_sdp = '0;
    m_pending = 1'b0;
  endtask

  function automatic logic [7:0] exp_seg(input int digit);
    logic [3:0] nib;
    nib = m_active[digit*4 +: 4];
    return ref_tab[nib] & ~{m_adp[digit], 7'b0};
  endfunction

  task automatic compare_outputs();
    int  digit;
    bit  show;
    digit = (t / DIV) % DIGITS;
    show  = (t % DIV) >= BLANK;
    check("sel", 32'(sel), 32'(digit));
    check("sel_en", 32'(sel_en), 32'(show));
    check("seg", 32'(seg), show ? 32'(exp_seg(digit)) : 32'hFF);
    check("frame_tick", 32'(frame_tick), 32'(t > 0 && (t % FRAME) == 0));
    check("pending", 32'(pending), 32'(m_pending));
  endtask

  task automatic check_reset_values();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_sel_en", 32'(sel_en), 32'd0);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
  endtask

  // Model update for the edge that ends cycle t.
  task automatic model_edge(input logic do_load, input logic [31:0] d, input logic [7:0] p);
    if (((t + 1) % FRAME) == 0) begin
      if (do_load) begin
        m_active = d; m_adp = p;
      end else if (m_pending) begin
        m_active = m_staged; m_adp = m_sdp;
      end
      m_pending = 1'b0;
    end else if (do_load) begin
      m_staged = d; m_sdp = p;
      m_pending = 1'b1;
    end
  endtask

  // Called at a negedge: checks cycle t, drives this cycle's inputs, advances one clock.
  task automatic run_cycle(input logic do_load, input logic [31:0] d, input logic [7:0] p);
    compare_outputs();
    load = do_load; disp_data = d; dp = p;
    model_edge(do_load, d, p);
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, $urandom, 8'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; disp_data = '0; dp = '0;
    model_reset();

    // Reset held
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Free-running timing over two frames
    idle(2 * FRAME);

    // Load mid-frame at frame cycle 10
    while ((t % FRAME) != 10) idle(1);
    run_cycle(1'b1, 32'h7654_3210, 8'h00);
    idle(2 * FRAME);

    // Load on the exact boundary edge
    while (((t + 1) % FRAME) != 0) idle(1);
    run_cycle(1'b1, 32'hFFFF_FFFF, 8'h00);
    idle(FRAME);

    // Double load within one frame: last load wins
    while ((t % FRAME) != 3) idle(1);
    run_cycle(1'b1, $urandom, 8'($urandom));
    idle(5);
    run_cycle(1'b1, $urandom, 8'h01);
    idle(2 * FRAME);

    // Random loads
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) run_cycle(1'b1, $urandom, 8'($urandom));
      else idle(1);
    end

    // Non-zero active buffer, then reset in a SHOW cycle of digit 5
    run_cycle(1'b1, 32'h89AB_CDEF, 8'hA5);
    idle(FRAME);
    while (!(((t % FRAME) / DIV) == 5 && (t % DIV) >= BLANK)) idle(1);
    compare_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    model_reset();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    idle(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
